// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin arbiter sharing one ROM read port; optional ROM_ARB_STATS_EN counters
module rom_read_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    output logic                     rom_en,
    output logic                     rom_flush,
    output logic [WIDTH-1:0]         rom_addr,
    input  logic [WIDTH-1:0]         rom_rd
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] tag_q, tag_d;

    logic             grant;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   scan_idx;
    logic             pend_vis;
    logic             rsp_on;

    // Scan requesters starting at rr_ptr, wrapping explicitly at NUM_REQ; first valid one wins
    always_comb begin
        grant    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant && !reset && !flush && req_valid[scan_idx[IDX_W-1:0]]) begin
                grant = 1'b1;
                win   = scan_idx[IDX_W-1:0];
            end
        end
    end

    // State, pointer and tag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
        end
    end

    // Next state: a grant (only possible without flush/reset) keeps or enters PEND
    always_comb begin
        state_d  = IDLE;
        rr_ptr_d = rr_ptr_q;
        tag_d    = tag_q;
        if (grant) begin
            state_d = PEND;
            tag_d   = win;
            if (win == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win + IDX_W'(1);
            end
        end
    end

    // Grant side and response side outputs; a flush in the response cycle suppresses it
    always_comb begin
        pend_vis  = (state_q == PEND) && !reset;
        rsp_on    = pend_vis && !flush;
        req_ready = grant ? (NUM_REQ'(1) << win) : '0;
        rom_en    = grant;
        rom_addr  = grant ? req_addr[win*WIDTH +: WIDTH] : '0;
        rom_flush = flush;
        busy      = pend_vis;
        rsp_valid = rsp_on ? (NUM_REQ'(1) << tag_q) : '0;
        rsp_data  = rsp_on ? rom_rd : '0;
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] stall_cnt_q;

    // Saturating grant and stall counters; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready[k] && (grant_cnt_q[k] != 16'hFFFF)) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
                end
            end
            if ((req_valid != '0) && !grant && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stall_cnt = stall_cnt_q;
`else
    // Statistics disabled: no counters or extra ports
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - table-driven self-checking bench for rom_read_arbiter
module tb_rom_read_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;
    logic                     rom_en;
    logic                     rom_flush;
    logic [WIDTH-1:0]         rom_addr;
    logic [WIDTH-1:0]         rom_rd;
`ifdef ROM_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]    grant_cnt;
    logic [15:0]              stall_cnt;
`endif

    always #5 clk = ~clk;

    rom_read_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rom_en    (rom_en),
        .rom_flush (rom_flush),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd)
`ifdef ROM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic [3:0]  vld;
        logic [31:0] rd;
        logic [3:0]  e_rdy;
        logic [31:0] e_addr;
        logic [3:0]  e_rsp;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic f, input logic [3:0] v, input logic [31:0] rd,
                       input logic [3:0] rdy, input logic [31:0] addr, input logic [3:0] rsp,
                       input logic bsy);
        vec_t t;
        t.rst = r; t.fl = f; t.vld = v; t.rd = rd;
        t.e_rdy = rdy; t.e_addr = addr; t.e_rsp = rsp; t.e_busy = bsy;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [31:0] rd);
        @(negedge clk);
        reset = r; flush = f; req_valid = v; rom_rd = rd;
        #2;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        rom_rd    = '0;
        req_addr  = {32'h0000_004C, 32'h0000_0038, 32'h0000_0024, 32'h0000_0010};

        // rst fl vld rom_rd | ready addr rsp busy
        add(1, 0, 4'b0000, 32'hC0DE_0000, 4'b0000, 32'h00, 4'b0000, 0); // 0 reset cycle
        add(0, 0, 4'b0000, 32'hC0DE_0001, 4'b0000, 32'h00, 4'b0000, 0); // 1 cycle after reset
        add(0, 0, 4'b0001, 32'hC0DE_0002, 4'b0001, 32'h10, 4'b0000, 0); // 2 single read
        add(0, 0, 4'b0000, 32'hDEAD_BEEF, 4'b0000, 32'h00, 4'b0001, 1); // 3 its response
        add(0, 0, 4'b0000, 32'h1234_5678, 4'b0000, 32'h00, 4'b0000, 0); // 4 idle, data gated
        add(1, 0, 4'b1111, 32'hC0DE_0005, 4'b0000, 32'h00, 4'b0000, 0); // 5 reset wins over valid
        add(0, 0, 4'b1111, 32'hC0DE_0006, 4'b0001, 32'h10, 4'b0000, 0); // 6 all valid rotation
        add(0, 0, 4'b1111, 32'hC0DE_0007, 4'b0010, 32'h24, 4'b0001, 1);
        add(0, 0, 4'b1111, 32'hC0DE_0008, 4'b0100, 32'h38, 4'b0010, 1);
        add(0, 0, 4'b1111, 32'hC0DE_0009, 4'b1000, 32'h4C, 4'b0100, 1);
        add(0, 0, 4'b1111, 32'hC0DE_000A, 4'b0001, 32'h10, 4'b1000, 1);
        add(0, 0, 4'b1111, 32'hC0DE_000B, 4'b0010, 32'h24, 4'b0001, 1);
        add(0, 0, 4'b1111, 32'hC0DE_000C, 4'b0100, 32'h38, 4'b0010, 1);
        add(0, 0, 4'b1111, 32'hC0DE_000D, 4'b1000, 32'h4C, 4'b0100, 1);
        add(0, 0, 4'b0000, 32'hC0DE_000E, 4'b0000, 32'h00, 4'b1000, 1); // 14 last response
        add(0, 0, 4'b0001, 32'hC0DE_000F, 4'b0001, 32'h10, 4'b0000, 0); // 15 moves rr_ptr to 1
        add(0, 0, 4'b0101, 32'hC0DE_0010, 4'b0100, 32'h38, 4'b0001, 1); // 16 sparse: 2
        add(0, 0, 4'b0101, 32'hC0DE_0011, 4'b0001, 32'h10, 4'b0100, 1); // 17 then 0
        add(0, 0, 4'b0101, 32'hC0DE_0012, 4'b0100, 32'h38, 4'b0001, 1); // 18 then 2
        add(0, 0, 4'b1000, 32'hC0DE_0013, 4'b1000, 32'h4C, 4'b0100, 1); // 19 grant 3
        add(0, 1, 4'b1000, 32'hC0DE_0014, 4'b0000, 32'h00, 4'b0000, 1); // 20 flush kills response
        add(0, 0, 4'b0000, 32'hC0DE_0015, 4'b0000, 32'h00, 4'b0000, 0); // 21 still nothing
        add(0, 0, 4'b0100, 32'hC0DE_0016, 4'b0100, 32'h38, 4'b0000, 0); // 22 grant 2 -> PEND
        add(1, 0, 4'b1111, 32'hC0DE_0017, 4'b0000, 32'h00, 4'b0000, 0); // 23 reset in PEND
        add(0, 0, 4'b1111, 32'hC0DE_0018, 4'b0001, 32'h10, 4'b0000, 0); // 24 rr_ptr back at 0
        add(0, 0, 4'b0000, 32'hC0DE_0019, 4'b0000, 32'h00, 4'b0001, 1);
        add(0, 0, 4'b0000, 32'hC0DE_001A, 4'b0000, 32'h00, 4'b0000, 0);
        add(0, 0, 4'b0010, 32'hC0DE_001B, 4'b0010, 32'h24, 4'b0000, 0); // 27 lone requester
        add(0, 0, 4'b0010, 32'hC0DE_001C, 4'b0010, 32'h24, 4'b0010, 1);
        add(0, 0, 4'b0010, 32'hC0DE_001D, 4'b0010, 32'h24, 4'b0010, 1);
        add(0, 0, 4'b0000, 32'hC0DE_001E, 4'b0000, 32'h00, 4'b0010, 1);
        add(0, 0, 4'b0000, 32'hC0DE_001F, 4'b0000, 32'h00, 4'b0000, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].vld, vecs[i].rd);
            chk("req_ready", i, 32'(req_ready), 32'(vecs[i].e_rdy));
            chk("rom_en",    i, 32'(rom_en),    32'(vecs[i].e_rdy != 4'b0000));
            chk("rom_addr",  i, rom_addr,       vecs[i].e_addr);
            chk("rom_flush", i, 32'(rom_flush), 32'(vecs[i].fl));
            chk("rsp_valid", i, 32'(rsp_valid), 32'(vecs[i].e_rsp));
            chk("rsp_data",  i, rsp_data,       (vecs[i].e_rsp != 4'b0000) ? vecs[i].rd : 32'h0);
            chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
        end

        // Flush in a grant cycle issues nothing and leaves rr_ptr (=2) untouched
        drive(0, 1, 4'b1111, 32'h0000_0BAD);
        chk("flush_ready", 100, 32'(req_ready), 32'h0);
        chk("flush_en",    100, 32'(rom_en),    32'h0);
        chk("flush_pin",   100, 32'(rom_flush), 32'h1);
        drive(0, 0, 4'b1111, 32'h0000_0BAD);
        chk("post_flush_ready", 101, 32'(req_ready), 32'h4);
        chk("post_flush_rsp",   101, 32'(rsp_valid), 32'h0);
        chk("post_flush_busy",  101, 32'(busy),      32'h0);
        drive(0, 0, 4'b0000, 32'h0000_FEED);
        chk("post_flush_rspv",  102, 32'(rsp_valid), 32'h4);
        chk("post_flush_data",  102, rsp_data,       32'h0000_FEED);

`ifdef ROM_ARB_STATS_EN
        // Five grants to requester 2, then three contended cycles blocked by flush
        drive(1, 0, 4'b0000, 32'h0);
        for (int n = 0; n < 5; n++) drive(0, 0, 4'b0100, 32'h0);
        for (int n = 0; n < 3; n++) drive(0, 1, 4'b0101, 32'h0);
        drive(0, 0, 4'b0000, 32'h0);
        chk("grant_cnt2", 200, 32'(grant_cnt[2*16 +: 16]), 32'd5);
        chk("grant_cnt0", 200, 32'(grant_cnt[0*16 +: 16]), 32'd0);
        chk("stall_cnt",  200, 32'(stall_cnt),             32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
